// File: rtl/tft_fill_rect.sv
// Purpose : paints a solid RGB565 rectangle by feeding the tft_spi byte transmitter
//           (0x2A column set, 0x2B page set, 0x2C memory write, then N pixel byte pairs).
// Latency : request accept -> first strobe 3 cycles; each byte then costs one full
//           tft_spi busy window plus 3 cycles of sequencing; done pulses one cycle after
//           the last byte's busy falls (2 cycles after start for a rejected request).
// Backpressure: never strobes while tft_busy is high; holds each byte until tft_busy
//           has risen and fallen again; start is ignored while busy or before init_done.
//
// Ports:
//   clk, global_reset (async, active high)
//   init_done, start, x0/x1/y0/y1 (inclusive bounds), color  : rectangle request
//   busy, done                                               : request status
//   tft_busy (in), tft_data, tft_dc, tft_transmit            : tft_spi byte interface
//
// Build option: define TFT_FILL_CLIP_EN to swap inverted bounds and clamp them to the
// panel (WIDTH-1 / HEIGHT-1); otherwise an inverted rectangle completes with no bytes.

module tft_fill_rect #(
  parameter int COORD_W = 9,
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240
) (
  input  logic               clk,
  input  logic               global_reset,
  input  logic               init_done,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [15:0]        color,
  output logic               busy,
  output logic               done,
  input  logic               tft_busy,
  output logic [7:0]         tft_data,
  output logic               tft_dc,
  output logic               tft_transmit
);

  localparam int NW = 2 * COORD_W;

  // Panel dimensions must be addressable with the coordinate width.
  if ((WIDTH > (1 << COORD_W)) || (HEIGHT > (1 << COORD_W))) begin : g_bad_dims
    $error("tft_fill_rect: COORD_W too narrow for WIDTH/HEIGHT");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [15:0]        color_q, color_d;
  logic [NW-1:0]      npix_q, npix_d;
  logic [3:0]         idx_q, idx_d;    // header byte index 0..10
  logic               pix_q, pix_d;    // set once the header is sent
  logic               hi_q, hi_d;      // next pixel byte is color[15:8]
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tx_q, tx_d;
  logic [7:0]         data_q, data_d;
  logic               dc_q, dc_d;

  // Normalised bounds and rejection flag used in CHECK.
  logic [COORD_W-1:0] cx0, cx1, cy0, cy1;
  logic               inverted;
  logic [NW-1:0]      w_ext, h_ext, npix_calc;

`ifdef TFT_FILL_CLIP_EN
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(HEIGHT - 1);

  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                               input logic [COORD_W-1:0] m);
    return (v > m) ? m : v;
  endfunction

  // Swap first so the clamp sees ordered bounds; a clamped rectangle is never inverted.
  assign cx0      = clamp((x0_q > x1_q) ? x1_q : x0_q, XMAX);
  assign cx1      = clamp((x0_q > x1_q) ? x0_q : x1_q, XMAX);
  assign cy0      = clamp((y0_q > y1_q) ? y1_q : y0_q, YMAX);
  assign cy1      = clamp((y0_q > y1_q) ? y0_q : y1_q, YMAX);
  assign inverted = 1'b0;
`else
  assign cx0      = x0_q;
  assign cx1      = x1_q;
  assign cy0      = y0_q;
  assign cy1      = y1_q;
  assign inverted = (x0_q > x1_q) || (y0_q > y1_q);
`endif

  // Extend before the +1 so a full-range span does not overflow.
  assign w_ext     = NW'(cx1) - NW'(cx0) + NW'(1);
  assign h_ext     = NW'(cy1) - NW'(cy0) + NW'(1);
  assign npix_calc = w_ext * h_ext;

  // Current byte and D/C for the SEND state.
  logic [15:0] ex0, ex1, ey0, ey1;
  logic [7:0]  cur_byte;
  logic        cur_dc;

  assign ex0 = 16'(x0_q);
  assign ex1 = 16'(x1_q);
  assign ey0 = 16'(y0_q);
  assign ey1 = 16'(y1_q);

  always_comb begin
    cur_byte = 8'h00;
    cur_dc   = 1'b1;
    if (pix_q) begin
      cur_byte = hi_q ? color_q[15:8] : color_q[7:0];
    end else begin
      case (idx_q)
        4'd0:    begin cur_byte = 8'h2A; cur_dc = 1'b0; end
        4'd1:    cur_byte = ex0[15:8];
        4'd2:    cur_byte = ex0[7:0];
        4'd3:    cur_byte = ex1[15:8];
        4'd4:    cur_byte = ex1[7:0];
        4'd5:    begin cur_byte = 8'h2B; cur_dc = 1'b0; end
        4'd6:    cur_byte = ey0[15:8];
        4'd7:    cur_byte = ey0[7:0];
        4'd8:    cur_byte = ey1[15:8];
        4'd9:    cur_byte = ey1[7:0];
        default: begin cur_byte = 8'h2C; cur_dc = 1'b0; end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    npix_d  = npix_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = 1'b0;
    data_d  = data_q;
    dc_d    = dc_q;

    case (state_q)
      S_IDLE: begin
        if (start && init_done) begin
          x0_d    = x0;
          x1_d    = x1;
          y0_d    = y0;
          y1_d    = y1;
          color_d = color;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        x0_d   = cx0;
        x1_d   = cx1;
        y0_d   = cy0;
        y1_d   = cy1;
        npix_d = npix_calc;
        idx_d  = 4'd0;
        pix_d  = 1'b0;
        hi_d   = 1'b1;
        if (inverted) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (!tft_busy) begin
          data_d  = cur_byte;
          dc_d    = cur_dc;
          tx_d    = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end

      // Only SEND can strobe, so a late busy rise just stretches this wait.
      S_WAIT_ACK: begin
        if (tft_busy) state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (!tft_busy) state_d = S_NEXT;
      end

      S_NEXT: begin
        state_d = S_SEND;
        if (!pix_q) begin
          if (idx_q == 4'd10) begin
            pix_d = 1'b1;
            hi_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (hi_q) begin
          hi_d = 1'b0;
        end else begin
          // Saturating count-down: the low byte of the last pixel ends the fill.
          if (npix_q <= NW'(1)) begin
            npix_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            npix_d = npix_q - NW'(1);
            hi_d   = 1'b1;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      npix_q  <= '0;
      idx_q   <= '0;
      pix_q   <= 1'b0;
      hi_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b0;
      data_q  <= 8'h00;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      npix_q  <= npix_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign tft_transmit = tx_q;
  assign tft_data     = data_q;
  assign tft_dc       = dc_q;

endmodule

// File: tb/tb_tft_fill_rect.sv
// Bench for tft_fill_rect: table of rectangle requests plus randomized requests,
// a tft_spi stand-in with configurable busy-rise delay, and a queue-based byte model.
module tb_tft_fill_rect;

  logic        clk = 1'b0;
  logic        global_reset, init_done, start;
  logic [8:0]  x0, x1, y0, y1;
  logic [15:0] color;
  logic        busy, done, tft_busy, tft_dc, tft_transmit;
  logic [7:0]  tft_data;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_dly  = 0;
  logic [8:0] cap_q[$];   // {dc, byte} as strobed
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  tft_fill_rect dut (
    .clk          (clk),
    .global_reset (global_reset),
    .init_done    (init_done),
    .start        (start),
    .x0           (x0),
    .x1           (x1),
    .y0           (y0),
    .y1           (y1),
    .color        (color),
    .busy         (busy),
    .done         (done),
    .tft_busy     (tft_busy),
    .tft_data     (tft_data),
    .tft_dc       (tft_dc),
    .tft_transmit (tft_transmit)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // tft_spi stand-in: busy rises ack_dly cycles after the strobe, stays high 4 cycles.
  initial begin : spi_model
    logic [7:0] hd;
    logic       hc;
    bit         rs;
    tft_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tft_transmit && !global_reset) begin
        cap_q.push_back({tft_dc, tft_data});
        hd = tft_data;
        hc = tft_dc;
        rs = 1'b0;
        for (int k = 0; k < ack_dly + 4; k++) begin
          if (k == ack_dly) tft_busy = 1'b1;
          @(negedge clk);
          if (global_reset) rs = 1'b1;
          if (!rs) begin
            chk("no_dup_strobe", tft_transmit, 0);
            chk("data_hold", {tft_dc, tft_data}, {hc, hd});
          end
        end
        tft_busy = 1'b0;
      end
    end
  end

  function automatic logic [8:0] db(input int v);
    return 9'(256 + (v & 255));
  endfunction

  // Reference byte stream for one request.
  function automatic void build_exp(input int a0, input int a1, input int b0, input int b1,
                                    input int col);
    int n;
    exp_q.delete();
`ifdef TFT_FILL_CLIP_EN
    begin
      int t;
      if (a0 > a1) begin t = a0; a0 = a1; a1 = t; end
      if (b0 > b1) begin t = b0; b0 = b1; b1 = t; end
      if (a0 > 319) a0 = 319;
      if (a1 > 319) a1 = 319;
      if (b0 > 239) b0 = 239;
      if (b1 > 239) b1 = 239;
    end
`else
    if (a0 > a1 || b0 > b1) return;
`endif
    n = (a1 - a0 + 1) * (b1 - b0 + 1);
    exp_q.push_back(9'h02A);
    exp_q.push_back(db(a0 >> 8)); exp_q.push_back(db(a0));
    exp_q.push_back(db(a1 >> 8)); exp_q.push_back(db(a1));
    exp_q.push_back(9'h02B);
    exp_q.push_back(db(b0 >> 8)); exp_q.push_back(db(b0));
    exp_q.push_back(db(b1 >> 8)); exp_q.push_back(db(b1));
    exp_q.push_back(9'h02C);
    repeat (n) begin
      exp_q.push_back(db(col >> 8));
      exp_q.push_back(db(col));
    end
  endfunction

  // poke >= 0: pulse start with other values at that cycle of the fill.
  // poke == -2: pulse start in the done cycle.
  task automatic run_req(input string nm, input int a0, input int a1, input int b0,
                         input int b1, input int col, input int dly, input int poke,
                         output int lat);
    int cyc;
    bit got, blow;
    ack_dly = dly;
    build_exp(a0, a1, b0, b1, col);
    cap_q.delete();
    @(negedge clk);
    x0 = 9'(a0); x1 = 9'(a1); y0 = 9'(b0); y1 = 9'(b1); color = 16'(col);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; got = 0; blow = 0;
    while (!got && cyc < 20000) begin
      if (done) got = 1;
      else begin
        if (!busy) blow = 1;
        if (cyc == poke) begin
          start = 1'b1; x0 = 9'd77; x1 = 9'd99; y0 = 9'd11; y1 = 9'd12; color = 16'hDEAD;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    lat = cyc + 1;
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_busy_held"}, blow, 0);
    chk({nm, "_busy_low_at_done"}, busy, 0);
    if (poke == -2) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_idle_after_done"}, busy, 0);
    chk({nm, "_strobe_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), cap_q[i], exp_q[i]);
  endtask

  typedef struct {
    int a0, a1, b0, b1, col, dly;
    int exp_n;    // expected strobe count
    int exp_lat;  // expected start->done cycles, -1 if not checked
  } vec_t;

  initial begin
    vec_t       vt[7];
    logic [8:0] lit0[13];
    int         lat, cyc;
    int         ra0, ra1, rb0, rb1;

    lit0 = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h100,
             9'h100, 9'h100, 9'h100, 9'h02C, 9'h1F8, 9'h100};
`ifdef TFT_FILL_CLIP_EN
    vt[0] = '{0, 0, 0, 0, 'hF800, 0, 13, -1};
    vt[1] = '{2, 3, 3, 5, 'h1234, 0, 23, -1};
    vt[2] = '{2, 3, 3, 5, 'h1234, 3, 23, -1};
    vt[3] = '{5, 1, 0, 0, 'hABCD, 1, 21, -1};
    vt[4] = '{316, 400, 0, 0, 'h0F0F, 0, 19, -1};
    vt[5] = '{0, 0, 7, 2, 'h00FF, 2, 23, -1};
    vt[6] = '{0, 0, 238, 300, 'h8001, 1, 15, -1};
`else
    vt[0] = '{0, 0, 0, 0, 'hF800, 0, 13, -1};
    vt[1] = '{2, 3, 3, 5, 'h1234, 0, 23, -1};
    vt[2] = '{2, 3, 3, 5, 'h1234, 3, 23, -1};
    vt[3] = '{5, 1, 0, 0, 'hABCD, 1, 0, 2};
    vt[4] = '{316, 400, 0, 0, 'h0F0F, 0, 181, -1};
    vt[5] = '{0, 0, 7, 2, 'h00FF, 2, 0, 2};
    vt[6] = '{0, 0, 238, 300, 'h8001, 1, 137, -1};
`endif

    global_reset = 1'b1; init_done = 1'b0; start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_transmit", tft_transmit, 0);
    chk("rst_dc", tft_dc, 0);
    chk("rst_data", tft_data, 0);
    global_reset = 1'b0;
    @(negedge clk);

    // start before init_done is ignored
    cap_q.delete();
    x0 = 9'd1; x1 = 9'd2; y0 = 9'd1; y1 = 9'd2; color = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("noinit_busy", busy, 0);
    chk("noinit_strobes", cap_q.size(), 0);
    init_done = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_req($sformatf("vec%0d", i), vt[i].a0, vt[i].a1, vt[i].b0, vt[i].b1,
              vt[i].col, vt[i].dly, -1, lat);
      chk($sformatf("vec%0d_count_const", i), cap_q.size(), vt[i].exp_n);
      if (vt[i].exp_lat >= 0) chk($sformatf("vec%0d_done_latency", i), lat, vt[i].exp_lat);
      if (i == 0)
        for (int j = 0; j < 13 && j < cap_q.size(); j++)
          chk($sformatf("vec0_literal%0d", j), cap_q[j], lit0[j]);
    end

    // start mid-fill and start in the done cycle are both ignored
    run_req("midstart", 2, 3, 3, 5, 'h1234, 1, 30, lat);
    run_req("midpix", 1, 2, 1, 1, 'h4321, 0, 150, lat);
    run_req("finstart", 1, 1, 1, 1, 'h5555, 0, -2, lat);

    // reset during the pixel phase
    ack_dly = 0;
    cap_q.delete();
    @(negedge clk);
    x0 = 9'd0; x1 = 9'd3; y0 = 9'd0; y1 = 9'd3; color = 16'hC3C3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cap_q.size() < 15 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_reached_pixels", cap_q.size() >= 15, 1);
    #2 global_reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_transmit", tft_transmit, 0);
    chk("midrst_dc", tft_dc, 0);
    chk("midrst_data", tft_data, 0);
    @(negedge clk);
    @(negedge clk);
    #2 global_reset = 1'b0;
    run_req("after_rst", 0, 0, 0, 0, 'h07E0, 0, -1, lat);

    // randomized requests, some inverted, some near the panel edge
    for (int r = 0; r < 16; r++) begin
      ra0 = ($urandom_range(0, 3) == 0 ? 314 : 0) + $urandom_range(0, 5);
      rb0 = ($urandom_range(0, 3) == 0 ? 235 : 0) + $urandom_range(0, 5);
      ra1 = ra0 + $urandom_range(0, 3);
      rb1 = rb0 + $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) ra0 = ra1 + $urandom_range(1, 3);
      if ($urandom_range(0, 5) == 0) rb0 = rb1 + $urandom_range(1, 2);
      run_req($sformatf("rnd%0d", r), ra0, ra1, rb0, rb1, int'($urandom_range(0, 65535)),
              $urandom_range(0, 3), -1, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tft_fill_rect.md
Name: tft_fill_rect

Overview:
- Controller that sequences the tft_spi transmitter to paint a solid-colour rectangle on the ILI9341-class panel.
- Takes one rectangle request: corners plus RGB565 colour.
- Issues the byte stream to tft_spi in order: column address set, page address set, memory write, then the pixel stream.
- Sits beside tft_init; becomes the SPI byte source once init_done is high.

Parameters:
- COORD_W, 9, coordinate width in bits (covers 0..319).
- WIDTH, 320, panel width in pixels; used only under the optional feature.
- HEIGHT, 240, panel height in pixels; used only under the optional feature.

Ports:
- clk  in  1  system clock.
- global_reset  in  1  asynchronous, active-high reset.
- init_done  in  1  high once tft_init has finished; requests are ignored while low.
- start  in  1  one-cycle request strobe.
- x0, x1  in  COORD_W  inclusive column bounds.
- y0, y1  in  COORD_W  inclusive row bounds.
- color  in  16  RGB565 fill colour.
- busy  out  1  high from request accept until done.
- done  out  1  one-cycle pulse at completion.
- tft_busy  in  1  busy from tft_spi.
- tft_data  out  8  byte to tft_spi.
- tft_dc  out  1  0 = command, 1 = data.
- tft_transmit  out  1  one-cycle transmit strobe to tft_spi.

Behaviour:
- Reset (async, any state): state IDLE; busy, done, tft_transmit, tft_dc = 0; tft_data = 0x00; all counters and latched inputs = 0. A byte already inside tft_spi is not aborted by this block.
- States: IDLE, CHECK, SEND, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - start=1 with init_done=1 latches x0/x1/y0/y1/color, sets busy=1 and goes to CHECK next cycle.
  - start while busy=1 or init_done=0 is ignored; no state change.
- CHECK:
  - Computes pixel count N = (x1-x0+1)*(y1-y0+1), width 2*COORD_W bits, unsigned.
  - Clears the byte index, then goes to SEND.
- SEND:
  - Waits while tft_busy=1.
  - When tft_busy=0: drives tft_data/tft_dc for the current byte, pulses tft_transmit for exactly 1 cycle, goes to WAIT_ACK.
- WAIT_ACK: waits for tft_busy=1, then goes to WAIT_DONE. A delayed busy rise must never cause a second strobe.
- WAIT_DONE: waits for tft_busy=0, then goes to NEXT.
- tft_data and tft_dc hold stable from the strobe cycle until WAIT_DONE exits.
- NEXT: advances the byte index; returns to SEND while bytes remain, otherwise goes to FINISH.
- Byte order (coordinates zero-extended to 16 bits, high byte first):
  - 0x2A (dc=0); x0 hi, x0 lo, x1 hi, x1 lo (dc=1).
  - 0x2B (dc=0); y0 hi, y0 lo, y1 hi, y1 lo (dc=1).
  - 0x2C (dc=0).
  - N repetitions of color[15:8], color[7:0] (dc=1).
- Total bytes per request = 11 + 2N.
- Pixel counter: counts down from N; the pixel phase ends when it reaches 0 after a low byte. No wrap-around.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. A start in the FINISH cycle is ignored.
- start is not accepted in the same cycle that done pulses.
- Inverted rectangle (x0>x1 or y0>y1): handled per the optional feature.

Optional Feature:
- Macro: TFT_FILL_CLIP_EN.
- Defined:
  - In CHECK, swap x0/x1 if x0>x1 and y0>y1 if y0>y1.
  - Then clamp every coordinate to WIDTH-1 / HEIGHT-1.
  - The rectangle is always drawn.
- Undefined:
  - An inverted request sends no bytes.
  - CHECK goes straight to FINISH: done pulses 2 cycles after start, and busy is high for those 2 cycles.
  - No clamping is applied.

Test Plan:
- Reset, init_done=1, model tft_spi with busy for 4 cycles per byte. Request (0,0)-(0,0), color 0xF800 -> exactly 13 strobes: 2A,00,00,00,00,2B,00,00,00,00,2C,F8,00, with dc = 0,1,1,1,1,0,1,1,1,1,0,1,1; then done pulses once.
- Request (2,3)-(3,5), color 0x1234 -> 23 strobes; column bytes 00 02 00 03; page bytes 00 03 00 05; then 6 pairs of 12 34; busy high throughout.
- Start pulsed mid-fill, and start pulsed with init_done=0 -> both ignored; byte count and latched values unchanged.
- tft_busy rise delayed 3 cycles after the strobe -> no duplicate tft_transmit; tft_data stable until busy falls.
- Request (5,0)-(1,0):
  - without TFT_FILL_CLIP_EN -> zero strobes, done 2 cycles after start;
  - with it -> column bytes 00 01 00 05, then 5 pixel pairs.
  - With the macro, x1=400 -> clamped to 0x013F.
- global_reset asserted during the pixel phase -> all outputs 0 immediately; a fresh request after release produces the full sequence from 0x2A.
